// File: rtl/risc_v_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire one
// instruction per rising CLK edge. Instruction ROM, 32x32 register file,
// ALU, immediate extender, branch/jump logic and word-addressed data RAM,
// with one memory-mapped input word (CPUIn) and one output register (CPUOut).
module risc_v_core #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFFC
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] CPUIn,
  output logic [31:0] CPUOut
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_BNE, CLS_JAL, CLS_LUI
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_e;

  // ROM image: every word starts as a nop.
  function automatic logic [IMEM_WORDS*32-1:0] load_rom();
    logic [IMEM_WORDS*32-1:0] flat;
    for (int i = 0; i < IMEM_WORDS; i++) flat[i*32 +: 32] = NOP_INSTR;
    return flat;
  endfunction

  logic [IMEM_WORDS*32-1:0] r_imem = load_rom();
  logic [31:0]              r_regs [32];
  logic [31:0]              r_dmem [DMEM_WORDS];

  // Debug-probe names are fixed so external tooling can find them.
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] ImmExt;
  logic [31:0] PCTarget;
  logic        PCSrc;
  logic [31:0] ALUResult;

  logic [IMEM_AW-1:0] w_imem_idx;
  logic [6:0]         w_opcode;
  logic [6:0]         w_funct7;
  logic [2:0]         w_funct3;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  cls_e               w_cls;
  alu_e               w_alu_op;
  logic               w_use_imm;
  logic [31:0]        w_rs1_data;
  logic [31:0]        w_rs2_data;
  logic [31:0]        w_alu_b;
  logic               w_alu_zero;
  logic [31:0]        w_pc_plus4;
  logic               w_is_io;
  logic [29:0]        w_word_addr;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [31:0]        w_dmem_rdata;
  logic               w_reg_we;
  logic [31:0]        w_wb_data;

  assign w_imem_idx = PC[IMEM_AW+1:2];

  // Fetch: indices beyond the ROM return a nop.
  always_comb begin
    Instr = NOP_INSTR;
    if (PC[31:2] < 30'(IMEM_WORDS)) Instr = r_imem[{w_imem_idx, 5'd0} +: 32];
  end

  assign w_opcode = Instr[6:0];
  assign w_rd     = Instr[11:7];
  assign w_funct3 = Instr[14:12];
  assign w_rs1    = Instr[19:15];
  assign w_rs2    = Instr[24:20];
  assign w_funct7 = Instr[31:25];

  // Decode into an instruction class and ALU operation; anything unknown is a nop.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_cls     = CLS_NOP;
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b1;
    case (w_opcode)
      7'b0110011: begin
        w_use_imm = 1'b0;
        w_cls     = CLS_ALU_R;
        case ({w_funct7, w_funct3})
          {7'h00, 3'd0}: w_alu_op = ALU_ADD;
          {7'h20, 3'd0}: w_alu_op = ALU_SUB;
          {7'h00, 3'd7}: w_alu_op = ALU_AND;
          {7'h00, 3'd6}: w_alu_op = ALU_OR;
          {7'h00, 3'd4}: w_alu_op = ALU_XOR;
          {7'h00, 3'd2}: w_alu_op = ALU_SLT;
          {7'h00, 3'd1}: w_alu_op = ALU_SLL;
          {7'h00, 3'd5}: w_alu_op = ALU_SRL;
          default:       w_cls    = CLS_NOP;
        endcase
      end
      7'b0010011: begin
        w_cls = CLS_ALU_I;
        case (w_funct3)
          3'd0:    w_alu_op = ALU_ADD;
          3'd7:    w_alu_op = ALU_AND;
          3'd6:    w_alu_op = ALU_OR;
          3'd4:    w_alu_op = ALU_XOR;
          3'd2:    w_alu_op = ALU_SLT;
          default: w_cls    = CLS_NOP;
        endcase
      end
      7'b0000011: if (w_funct3 == 3'd2) w_cls = CLS_LW;
      7'b0100011: if (w_funct3 == 3'd2) w_cls = CLS_SW;
      7'b1100011: begin
        w_use_imm = 1'b0;
        w_alu_op  = ALU_SUB;
        if (w_funct3 == 3'd0)      w_cls = CLS_BEQ;
        else if (w_funct3 == 3'd1) w_cls = CLS_BNE;
      end
      7'b1101111: w_cls = CLS_JAL;
      7'b0110111: w_cls = CLS_LUI;
      default:    w_cls = CLS_NOP;
    endcase
  end

  // Immediate extender: pick the format implied by the instruction class.
  always_comb begin
    ImmExt = 32'd0;
    case (w_cls)
      CLS_ALU_I, CLS_LW: ImmExt = {{20{Instr[31]}}, Instr[31:20]};
      CLS_SW:            ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      CLS_BEQ, CLS_BNE:  ImmExt = {{19{Instr[31]}}, Instr[31], Instr[7],
                                   Instr[30:25], Instr[11:8], 1'b0};
      CLS_JAL:           ImmExt = {{11{Instr[31]}}, Instr[31], Instr[19:12],
                                   Instr[20], Instr[30:21], 1'b0};
      CLS_LUI:           ImmExt = {Instr[31:12], 12'd0};
      default:           ImmExt = 32'd0;
    endcase
  end

  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_alu_b    = w_use_imm ? ImmExt : w_rs2_data;

  // ALU: branches use SUB so equality is just a zero result.
  always_comb begin
    ALUResult = 32'd0;
    case (w_alu_op)
      ALU_ADD: ALUResult = w_rs1_data + w_alu_b;
      ALU_SUB: ALUResult = w_rs1_data - w_alu_b;
      ALU_AND: ALUResult = w_rs1_data & w_alu_b;
      ALU_OR:  ALUResult = w_rs1_data | w_alu_b;
      ALU_XOR: ALUResult = w_rs1_data ^ w_alu_b;
      ALU_SLT: ALUResult = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
      ALU_SLL: ALUResult = w_rs1_data << w_alu_b[4:0];
      ALU_SRL: ALUResult = w_rs1_data >> w_alu_b[4:0];
      default: ALUResult = 32'd0;
    endcase
  end

  assign w_alu_zero = (ALUResult == 32'd0);
  assign w_pc_plus4 = PC + 32'd4;
  assign PCTarget   = PC + ImmExt;
  assign PCSrc      = ((w_cls == CLS_BEQ) &&  w_alu_zero) ||
                      ((w_cls == CLS_BNE) && !w_alu_zero) ||
                       (w_cls == CLS_JAL);

  assign w_is_io      = (ALUResult == IO_ADDR);
  assign w_word_addr  = ALUResult[31:2];
  assign w_dmem_idx   = DMEM_AW'(w_word_addr % 30'(DMEM_WORDS));
  assign w_dmem_rdata = r_dmem[w_dmem_idx];

  // Write-back source select; only value-producing classes enable the write.
  always_comb begin
    w_reg_we  = 1'b0;
    w_wb_data = ALUResult;
    case (w_cls)
      CLS_ALU_R, CLS_ALU_I: w_reg_we = 1'b1;
      CLS_LW: begin
        w_reg_we  = 1'b1;
        w_wb_data = w_is_io ? CPUIn : w_dmem_rdata;
      end
      CLS_JAL: begin
        w_reg_we  = 1'b1;
        w_wb_data = w_pc_plus4;
      end
      CLS_LUI: begin
        w_reg_we  = 1'b1;
        w_wb_data = ImmExt;
      end
      default: w_reg_we = 1'b0;
    endcase
  end

  // Program counter: taken branch/jump target, otherwise the next word.
  always_ff @(posedge CLK or posedge Reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Reset) PC <= 32'd0;
    else       PC <= PCSrc ? PCTarget : w_pc_plus4;
  end

  // Output register: loaded only by a store to the I/O address.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                CPUOut <= 32'd0;
    else if ((w_cls == CLS_SW) && w_is_io)    CPUOut <= w_rs2_data;
  end

  // Register file write port; x0 is never written so it stays zero.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_reg_we && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_wb_data;
    end
  end

  // Data RAM write port; stores to the I/O address bypass it.
  always_ff @(posedge CLK) begin
    // NOTE: the RAM keeps its contents across reset, so it has no reset branch.
    if ((w_cls == CLS_SW) && !w_is_io && !Reset) r_dmem[w_dmem_idx] <= w_rs2_data;
  end

endmodule

// File: tb/tb_risc_v_core.sv
// Self-checking bench for risc_v_core: directed program for the named
// scenarios, then random programs checked against an instruction-level model.
module tb_risc_v_core;

  localparam int          IMEM_WORDS = 64;
  localparam int          DMEM_WORDS = 64;
  localparam logic [31:0] IO_ADDR    = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        CLK;
  logic        Reset;
  logic [31:0] CPUIn;
  logic [31:0] CPUOut;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom   [IMEM_WORDS];
  logic [31:0] m_x   [32];
  logic [31:0] m_mem [DMEM_WORDS];
  logic [31:0] m_pc;
  logic [31:0] m_out;

  risc_v_core #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS),
    .IMEM_FILE (""),
    .IO_ADDR   (IO_ADDR)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .CPUIn (CPUIn),
    .CPUOut(CPUOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[19:0], rd, 7'h37};
  endfunction

  // ---------------- instruction-level reference model ----------------
  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    logic [31:0] idx;
    idx = pc >> 2;
    return (idx < IMEM_WORDS) ? rom[idx] : NOP;
  endfunction

  task automatic m_reset();
    m_pc  = 32'd0;
    m_out = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  // Retire one instruction in the model (what the ISA says it does).
  task automatic m_step(input logic [31:0] cpu_in);
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, addr, val, nxt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr;
    int          widx;
    ins   = m_fetch(m_pc);
    f3    = ins[14:12];
    rd    = ins[11:7];
    a     = m_x[ins[19:15]];
    b     = m_x[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt   = m_pc + 32'd4;
    wr    = 1'b0;
    val   = 32'd0;
    case (ins[6:0])
      7'h33: begin
        wr = 1'b1;
        case ({ins[31:25], f3})
          {7'h00, 3'd0}: val = a + b;
          {7'h20, 3'd0}: val = a - b;
          {7'h00, 3'd7}: val = a & b;
          {7'h00, 3'd6}: val = a | b;
          {7'h00, 3'd4}: val = a ^ b;
          {7'h00, 3'd2}: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd1}: val = a << b[4:0];
          {7'h00, 3'd5}: val = a >> b[4:0];
          default:       wr  = 1'b0;
        endcase
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0:    val = a + imm_i;
          3'd7:    val = a & imm_i;
          3'd6:    val = a | imm_i;
          3'd4:    val = a ^ imm_i;
          3'd2:    val = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
          default: wr  = 1'b0;
        endcase
      end
      7'h03: if (f3 == 3'd2) begin
        addr = a + imm_i;
        widx = int'((addr >> 2) % DMEM_WORDS);
        wr   = 1'b1;
        val  = (addr == IO_ADDR) ? cpu_in : m_mem[widx];
      end
      7'h23: if (f3 == 3'd2) begin
        addr = a + imm_s;
        widx = int'((addr >> 2) % DMEM_WORDS);
        if (addr == IO_ADDR) m_out = b;
        else                 m_mem[widx] = b;
      end
      7'h63: begin
        if ((f3 == 3'd0) && (a == b)) nxt = m_pc + imm_b;
        if ((f3 == 3'd1) && (a != b)) nxt = m_pc + imm_b;
      end
      7'h6F: begin
        wr  = 1'b1;
        val = m_pc + 32'd4;
        nxt = m_pc + imm_j;
      end
      7'h37: begin
        wr  = 1'b1;
        val = {ins[31:12], 12'd0};
      end
      default: ;
    endcase
    if (wr && (rd != 5'd0)) m_x[rd] = val;
    m_pc = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] r;
    int          k, words;
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    r   = $urandom;
    k   = $urandom_range(0, 99);
    words = ($urandom_range(0, 4) == 0) ? -$urandom_range(1, 2) : $urandom_range(1, 6);
    if (k < 20) begin
      f7 = 7'h00;
      case ($urandom_range(0, 7))
        0: f3 = 3'd0;
        1: begin f3 = 3'd0; f7 = 7'h20; end
        2: f3 = 3'd7;
        3: f3 = 3'd6;
        4: f3 = 3'd4;
        5: f3 = 3'd2;
        6: f3 = 3'd1;
        default: f3 = 3'd5;
      endcase
      return enc_r(f7, rs2, rs1, f3, rd);
    end else if (k < 40) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd7;
        2: f3 = 3'd6;
        3: f3 = 3'd4;
        default: f3 = 3'd2;
      endcase
      return enc_i(r, rs1, f3, rd, 7'h13);
    end else if (k < 48) begin
      return enc_u(r, rd);
    end else if (k < 58) begin
      if (r[31]) return enc_i(32'hFFFF_FFFC, 5'd0, 3'd2, rd, 7'h03);
      return enc_i(r, rs1, 3'd2, rd, 7'h03);
    end else if (k < 70) begin
      if (r[31]) return enc_s(32'hFFFF_FFFC, rs2, 5'd0);
      return enc_s(r, rs2, rs1);
    end else if (k < 82) begin
      return enc_b(32'(words * 4), rs2, rs1, {2'b00, r[0]});
    end else if (k < 88) begin
      return enc_j(32'(words * 4), rd);
    end else if (k < 94) begin
      if (r[1:0] == 2'd0) return 32'h0000_0000;
      if (r[1:0] == 2'd1) return {r[31:7], 7'h17};
      return {r[31:7], 7'h0F};
    end
    return NOP;
  endfunction

  task automatic load_program();
    for (int i = 0; i < IMEM_WORDS; i++) dut.r_imem[i*32 +: 32] = rom[i];
  endtask

  task automatic load_dmem();
    for (int i = 0; i < DMEM_WORDS; i++) begin
      m_mem[i]      = $urandom;
      dut.r_dmem[i] = m_mem[i];
    end
  endtask

  // Compare architectural state, retire one instruction in the model, clock the DUT.
  task automatic step();
    string where;
    where = $sformatf("@%h", m_pc);
    check({"pc", where},    dut.PC,    m_pc);
    check({"cpuout", where}, CPUOut,   m_out);
    check({"instr", where}, dut.Instr, m_fetch(m_pc));
    m_step(CPUIn);
    @(posedge CLK);
    #2;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 1; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.r_regs[i], m_x[i]);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DMEM_WORDS; i++) check($sformatf("%s_m%0d", tag, i), dut.r_dmem[i], m_mem[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1'b1;
    CPUIn = 32'd131;
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = NOP;
    rom[0]  = enc_i(32'hFFFF_FFFC, 5'd0, 3'd2, 5'd1, 7'h03); // lw   x1,-4(x0)
    rom[1]  = enc_s(32'hFFFF_FFFC, 5'd1, 5'd0);              // sw   x1,-4(x0)
    rom[2]  = enc_i(32'd5, 5'd0, 3'd0, 5'd2, 7'h13);         // addi x2,x0,5
    rom[3]  = enc_i(32'hFFFF_FFFD, 5'd0, 3'd0, 5'd3, 7'h13); // addi x3,x0,-3
    rom[4]  = enc_b(32'd12, 5'd0, 5'd0, 3'd0);               // beq  x0,x0,+12
    rom[6]  = enc_j(32'd16, 5'd0);                           // jal  x0,+16
    rom[7]  = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd4);          // add  x4,x2,x3
    rom[8]  = enc_j(32'hFFFF_FFF8, 5'd1);                    // jal  x1,-8
    rom[10] = enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd5);          // sub  x5,x2,x3
    rom[11] = enc_r(7'h00, 5'd2, 5'd3, 3'd2, 5'd6);          // slt  x6,x3,x2
    rom[12] = enc_u(32'h12345, 5'd7);                        // lui  x7,0x12345
    rom[13] = 32'h0000_0000;                                 // undefined
    rom[14] = enc_b(32'd12, 5'd0, 5'd0, 3'd1);               // bne  x0,x0,+12
    #1;
    load_program();
    load_dmem();
    m_reset();

    // Reset held ~100 ns with the clock running: nothing advances.
    repeat (10) begin
      @(negedge CLK);
      check("rst_pc", dut.PC, 32'd0);
      check("rst_cpuout", CPUOut, 32'd0);
      check("rst_instr", dut.Instr, rom[0]);
    end
    #2;
    Reset = 1'b0;

    step();
    step();
    check("io_cpuout", CPUOut, 32'h0000_0083);
    check("io_pc", dut.PC, 32'h0000_0008);
    step();
    step();
    check("beq_pcsrc", dut.PCSrc, 32'd1);
    check("beq_imm", dut.ImmExt, 32'h0000_000C);
    check("beq_target", dut.PCTarget, 32'h0000_001C);
    step();
    check("beq_next", dut.PC, 32'h0000_001C);
    step();
    step();
    check("jal_link", dut.r_regs[1], 32'h0000_0024);
    check("jal_pc", dut.PC, 32'h0000_0018);
    step();
    check("sub_alu", dut.ALUResult, 32'h0000_0008);
    step();
    step();
    step();
    check("add_x4", dut.r_regs[4], 32'd2);
    check("sub_x5", dut.r_regs[5], 32'd8);
    check("slt_x6", dut.r_regs[6], 32'd1);
    check("lui_x7", dut.r_regs[7], 32'h1234_5000);
    step();
    check("undef_pc", dut.PC, 32'h0000_0038);
    check("bne_pcsrc", dut.PCSrc, 32'd0);
    step();
    check("bne_next", dut.PC, 32'h0000_003C);
    check_regs("dir");

    // Asynchronous reset between edges.
    #1;
    Reset = 1'b1;
    #1;
    check("arst_pc", dut.PC, 32'd0);
    check("arst_cpuout", CPUOut, 32'd0);
    check("arst_instr", dut.Instr, rom[0]);
    check("arst_x4", dut.r_regs[4], 32'd0);
    m_reset();
    @(posedge CLK);
    #2;
    check("arst_hold_pc", dut.PC, 32'd0);
    Reset = 1'b0;
    repeat (4) step();
    check("restart_pc", dut.PC, 32'h0000_0010);

    // Random programs against the model.
    for (int r = 0; r < 6; r++) begin
      Reset = 1'b1;
      m_reset();
      for (int i = 0; i < IMEM_WORDS; i++) rom[i] = gen_instr();
      load_program();
      load_dmem();
      CPUIn = $urandom;
      #1;
      check("rnd_rst_pc", dut.PC, 32'd0);
      Reset = 1'b0;
      repeat (120) begin
        if ($urandom_range(0, 1) == 1) CPUIn = $urandom;
        step();
      end
      check_regs($sformatf("rnd%0d", r));
      check_mem($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
